hdmi_config_sequencer: RTL and testbench

- Upstream command source for the I2C controller.
- After power-up, and again after every HDMI hot-plug assertion, it walks a fixed table of HDMI-transmitter register writes (address byte, data byte).
- For each entry it issues one start request to the I2C controller, waits for the controller's stop pulse, and checks for NACK/timeout with bounded retry.
- It reports config_done or config_error to the top level.

---
 rtl/hdmi_config_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_hdmi_config_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_config_sequencer.sv
// HDMI transmitter configuration sequencer: walks a fixed register table
// through an I2C controller, with NACK/timeout retry and hot-plug replay.
module hdmi_config_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR    = 8'h72,
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned POWERUP_DELAY = 100,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic        clock_100khz,
  input  logic        reset,
  input  logic        hpd,
  input  logic        i2c_stop,
  input  logic        i2c_ack,
  output logic        i2c_start,
  output logic [15:0] register_data,
  output logic [7:0]  slave_address,
  output logic [2:0]  reg_index,
  output logic        config_done,
  output logic        config_error
);

  typedef enum logic [2:0] {
    S_DELAY,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] L_DLY_END = 16'(POWERUP_DELAY - 1);
  localparam logic [15:0] L_GAP_END = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] L_TMO_END = 16'(TIMEOUT - 1);
  localparam logic [3:0]  L_MAX_TRY = 4'(MAX_RETRIES);
  localparam logic [2:0]  L_LAST    = 3'(NUM_REGS - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_timer;
  logic [3:0]  r_retry;
  logic        r_nack;
  logic        r_tmo;
  logic        r_hpd_q;
  logic        r_hpd_pend;
  logic        r_start;
  logic [15:0] r_data;
  logic [7:0]  r_addr;
  logic [2:0]  r_idx;
  logic        r_done;
  logic        r_error;

  logic [15:0] w_entry;
  logic        w_hpd_rise;
  logic        w_fail;
  logic [3:0]  w_retry_nxt;

  always_comb begin
    w_entry = 16'h0000;
    case (r_idx)
      3'd0: w_entry = 16'h4110;
      3'd1: w_entry = 16'h9803;
      3'd2: w_entry = 16'h9AE0;
      3'd3: w_entry = 16'h9C30;
      3'd4: w_entry = 16'h9D61;
      3'd5: w_entry = 16'hA2A4;
      3'd6: w_entry = 16'hA3A4;
      3'd7: w_entry = 16'hAF06;
      default: w_entry = 16'h0000;
    endcase
  end

  assign w_hpd_rise  = hpd & ~r_hpd_q;
  assign w_fail      = r_nack | r_tmo;
  assign w_retry_nxt = r_retry + 4'd1;

  always_ff @(posedge clock_100khz) begin
    if (reset) begin
      r_state    <= S_DELAY;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_retry    <= '0;
      r_nack     <= 1'b0;
      r_tmo      <= 1'b0;
      r_hpd_q    <= hpd;
      r_hpd_pend <= 1'b0;
      r_start    <= 1'b0;
      r_data     <= '0;
      r_addr     <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_hpd_q <= hpd;
      r_start <= 1'b0;
      // edges seen mid-sequence are replayed once the sequence settles
      if (w_hpd_rise)
        r_hpd_pend <= 1'b1;
      unique case (r_state)
        S_DELAY: begin
          if (r_cnt == L_DLY_END) begin
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_LOAD: begin
          r_data  <= w_entry;
          r_addr  <= SLAVE_ADDR;
          r_nack  <= 1'b0;
          r_tmo   <= 1'b0;
          r_timer <= '0;
          r_start <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i2c_ack)
            r_nack <= 1'b1;
          if (!i2c_stop) begin
            r_state <= S_CHECK;
          end else if (r_timer == L_TMO_END) begin
            r_tmo   <= 1'b1;
            r_state <= S_CHECK;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_CHECK: begin
          r_cnt <= '0;
          if (!w_fail) begin
            r_retry <= '0;
            if (r_idx == L_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_GAP;
            end
          end else begin
            r_retry <= w_retry_nxt;
            if (w_retry_nxt == L_MAX_TRY) begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end else begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == L_GAP_END) begin
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE, S_ERROR: begin
          if (w_hpd_rise || r_hpd_pend) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_idx      <= '0;
            r_retry    <= '0;
            r_cnt      <= '0;
            r_hpd_pend <= 1'b0;
            r_state    <= S_DELAY;
          end
        end
      endcase
    end
  end

  assign i2c_start     = r_start;
  assign register_data = r_data;
  assign slave_address = r_addr;
  assign reg_index     = r_idx;
  assign config_done   = r_done;
  assign config_error  = r_error;

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Directed bench for hdmi_config_sequencer with a behavioural
// I2C controller model that can NACK or hang on chosen entries.
module tb_hdmi_config_sequencer;

  logic        clock_100khz = 1'b0;
  logic        reset = 1'b1;
  logic        hpd = 1'b0;
  logic        i2c_stop = 1'b1;
  logic        i2c_ack = 1'b0;
  logic        i2c_start;
  logic [15:0] register_data;
  logic [7:0]  slave_address;
  logic [2:0]  reg_index;
  logic        config_done;
  logic        config_error;

  always #5 clock_100khz = ~clock_100khz;

  hdmi_config_sequencer dut (
    .clock_100khz (clock_100khz),
    .reset        (reset),
    .hpd          (hpd),
    .i2c_stop     (i2c_stop),
    .i2c_ack      (i2c_ack),
    .i2c_start    (i2c_start),
    .register_data(register_data),
    .slave_address(slave_address),
    .reg_index    (reg_index),
    .config_done  (config_done),
    .config_error (config_error)
  );

  int passed = 0;
  int total  = 0;

  // 0: ack all, 1: NACK entry 2 once, 2: NACK entry 4 always, 3: hang
  int mode = 0;
  int stop_dly = 90;

  int     busy = 0;
  int     mcnt = 0;
  bit     nacked_once = 1'b0;
  int     starts = 0;
  longint cyc = 0;
  logic [15:0] log_data [0:127];
  logic [2:0]  log_idx  [0:127];
  longint      log_time [0:127];

  logic [15:0] exp_tbl [0:7] = '{
    16'h4110, 16'h9803, 16'h9AE0, 16'h9C30,
    16'h9D61, 16'hA2A4, 16'hA3A4, 16'hAF06
  };

  always @(posedge clock_100khz) cyc = cyc + 1;

  always @(negedge clock_100khz) begin
    i2c_ack  = 1'b0;
    i2c_stop = 1'b1;
    if (reset) begin
      busy = 0;
      nacked_once = 1'b0;
    end else if (i2c_start) begin
      log_data[starts % 128] = register_data;
      log_idx[starts % 128]  = reg_index;
      log_time[starts % 128] = cyc;
      starts = starts + 1;
      busy = 1;
      mcnt = 0;
    end else if (busy != 0) begin
      mcnt = mcnt + 1;
      if (mode == 1 && !nacked_once && register_data == 16'h9AE0 && mcnt == 10) begin
        i2c_ack = 1'b1;
        nacked_once = 1'b1;
      end
      if (mode == 2 && register_data == 16'h9D61 && mcnt == 10)
        i2c_ack = 1'b1;
      if (mode != 3 && mcnt == stop_dly) begin
        i2c_stop = 1'b0;
        busy = 0;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clock_100khz);
    reset = 1'b1;
    repeat (2) @(posedge clock_100khz);
    #1;
  endtask

  task automatic release_and_count(output int n);
    @(negedge clock_100khz);
    reset = 1'b0;
    n = 0;
    while (n < 1000) begin
      @(posedge clock_100khz);
      #1;
      n++;
      if (i2c_start) break;
    end
  endtask

  task automatic wait_end(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(posedge clock_100khz);
      #1;
      if (config_done || config_error) break;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (i2c_start !== 1'b0) $display("FAIL rst_start: got %b exp 0", i2c_start);
    else passed++;
    total++;
    if (register_data !== 16'h0000) $display("FAIL rst_data: got %h exp 0000", register_data);
    else passed++;
    total++;
    if (slave_address !== 8'h00) $display("FAIL rst_addr: got %h exp 00", slave_address);
    else passed++;
    total++;
    if (reg_index !== 3'd0) $display("FAIL rst_idx: got %0d exp 0", reg_index);
    else passed++;
    total++;
    if (config_done !== 1'b0 || config_error !== 1'b0)
      $display("FAIL rst_flags: got %b%b exp 00", config_done, config_error);
    else passed++;
  endtask

  task automatic test_normal();
    int n;
    int base;
    base = starts;
    mode = 0;
    release_and_count(n);
    total++;
    if (n != 101) $display("FAIL first_start_cycle: got %0d exp 101", n);
    else passed++;
    total++;
    if (register_data !== 16'h4110) $display("FAIL first_data: got %h exp 4110", register_data);
    else passed++;
    total++;
    if (slave_address !== 8'h72) $display("FAIL first_addr: got %h exp 72", slave_address);
    else passed++;
    wait_end(3000);
    total++;
    if (starts - base != 8) $display("FAIL normal_starts: got %0d exp 8", starts - base);
    else passed++;
    total++;
    if (config_done !== 1'b1 || config_error !== 1'b0)
      $display("FAIL normal_flags: got %b%b exp 10", config_done, config_error);
    else passed++;
    total++;
    if (reg_index !== 3'd7) $display("FAIL normal_idx: got %0d exp 7", reg_index);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (log_data[(base + i) % 128] !== exp_tbl[i])
        $display("FAIL normal_entry%0d: got %h exp %h", i, log_data[(base + i) % 128], exp_tbl[i]);
      else passed++;
    end
    repeat (50) @(posedge clock_100khz);
    #1;
    total++;
    if (starts - base != 8 || config_done !== 1'b1)
      $display("FAIL done_hold: got starts %0d done %b exp 8 1", starts - base, config_done);
    else passed++;
  endtask

  task automatic test_hotplug();
    int n;
    int base;
    base = starts;
    @(negedge clock_100khz);
    hpd = 1'b1;
    @(posedge clock_100khz);
    #1;
    n = 1;
    total++;
    if (config_done !== 1'b0) $display("FAIL hpd_done_clr: got %b exp 0", config_done);
    else passed++;
    while (n < 1000 && !i2c_start) begin
      @(posedge clock_100khz);
      #1;
      n++;
    end
    total++;
    if (n != 102) $display("FAIL hpd_start_cycle: got %0d exp 102", n);
    else passed++;
    total++;
    if (register_data !== 16'h4110) $display("FAIL hpd_first_data: got %h exp 4110", register_data);
    else passed++;
    wait_end(3000);
    total++;
    if (starts - base != 8 || config_done !== 1'b1)
      $display("FAIL hpd_replay: got starts %0d done %b exp 8 1", starts - base, config_done);
    else passed++;
    @(negedge clock_100khz);
    hpd = 1'b0;
    repeat (200) @(posedge clock_100khz);
    #1;
    total++;
    if (starts - base != 8 || config_done !== 1'b1)
      $display("FAIL hpd_low: got starts %0d done %b exp 8 1", starts - base, config_done);
    else passed++;
  endtask

  task automatic test_nack_once();
    int n;
    int base;
    apply_reset();
    base = starts;
    mode = 1;
    release_and_count(n);
    wait_end(4000);
    total++;
    if (starts - base != 9) $display("FAIL nack1_starts: got %0d exp 9", starts - base);
    else passed++;
    total++;
    if (log_data[(base + 2) % 128] !== 16'h9AE0 || log_data[(base + 3) % 128] !== 16'h9AE0)
      $display("FAIL nack1_reissue: got %h %h exp 9ae0 9ae0",
               log_data[(base + 2) % 128], log_data[(base + 3) % 128]);
    else passed++;
    total++;
    if (log_idx[(base + 3) % 128] !== 3'd2)
      $display("FAIL nack1_idx: got %0d exp 2", log_idx[(base + 3) % 128]);
    else passed++;
    total++;
    if (log_data[(base + 8) % 128] !== 16'hAF06)
      $display("FAIL nack1_last: got %h exp af06", log_data[(base + 8) % 128]);
    else passed++;
    total++;
    if (config_done !== 1'b1 || config_error !== 1'b0)
      $display("FAIL nack1_flags: got %b%b exp 10", config_done, config_error);
    else passed++;
  endtask

  task automatic test_nack_entry4();
    int n;
    int base;
    int hits;
    apply_reset();
    base = starts;
    mode = 2;
    release_and_count(n);
    wait_end(4000);
    total++;
    if (config_error !== 1'b1 || config_done !== 1'b0)
      $display("FAIL nack4_flags: got %b%b exp 01", config_done, config_error);
    else passed++;
    total++;
    if (reg_index !== 3'd4) $display("FAIL nack4_idx: got %0d exp 4", reg_index);
    else passed++;
    hits = 0;
    for (int i = 0; i < starts - base && i < 64; i++)
      if (log_data[(base + i) % 128] == 16'h9D61) hits++;
    total++;
    if (hits != 3) $display("FAIL nack4_attempts: got %0d exp 3", hits);
    else passed++;
    repeat (600) @(posedge clock_100khz);
    #1;
    total++;
    if (starts - base != 7) $display("FAIL nack4_starts: got %0d exp 7", starts - base);
    else passed++;
    mode = 0;
  endtask

  task automatic test_timeout();
    int n;
    int base;
    longint gap;
    apply_reset();
    base = starts;
    mode = 3;
    release_and_count(n);
    wait_end(3000);
    total++;
    if (config_error !== 1'b1) $display("FAIL tmo_error: got %b exp 1", config_error);
    else passed++;
    total++;
    if (reg_index !== 3'd0 || starts - base != 3)
      $display("FAIL tmo_idx_starts: got %0d %0d exp 0 3", reg_index, starts - base);
    else passed++;
    gap = log_time[(base + 1) % 128] - log_time[base % 128];
    total++;
    if (gap != 262) $display("FAIL tmo_spacing: got %0d exp 262", gap);
    else passed++;
    total++;
    if (log_data[(base + 2) % 128] !== 16'h4110)
      $display("FAIL tmo_retry_data: got %h exp 4110", log_data[(base + 2) % 128]);
    else passed++;
    mode = 0;
  endtask

  task automatic test_reset_midwait();
    int n;
    int base;
    int k;
    apply_reset();
    base = starts;
    mode = 0;
    release_and_count(n);
    k = 0;
    while (starts - base < 4 && k < 2000) begin
      @(posedge clock_100khz);
      k++;
    end
    repeat (20) @(posedge clock_100khz);
    #1;
    total++;
    if (reg_index !== 3'd3 || register_data !== 16'h9C30)
      $display("FAIL mid_pre: got %0d %h exp 3 9c30", reg_index, register_data);
    else passed++;
    @(negedge clock_100khz);
    reset = 1'b1;
    @(posedge clock_100khz);
    #1;
    total++;
    if (i2c_start !== 1'b0 || register_data !== 16'h0000 || slave_address !== 8'h00 ||
        reg_index !== 3'd0 || config_done !== 1'b0 || config_error !== 1'b0)
      $display("FAIL mid_reset_vals: got %b %h %h %0d %b %b exp 0 0000 00 0 0 0",
               i2c_start, register_data, slave_address, reg_index, config_done, config_error);
    else passed++;
    release_and_count(n);
    total++;
    if (n != 101) $display("FAIL mid_restart_cycle: got %0d exp 101", n);
    else passed++;
    total++;
    if (register_data !== 16'h4110 || reg_index !== 3'd0)
      $display("FAIL mid_restart_entry: got %h %0d exp 4110 0", register_data, reg_index);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hotplug();
    test_nack_once();
    test_nack_entry4();
    test_timeout();
    test_reset_midwait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
